// File: rtl/booth_multiplier.sv
// booth_multiplier: multicycle signed 32x32 multiplier using radix-4 modified Booth recoding.
// Each iteration adds 0, +/-M or +/-2M into the upper 34 bits of a 67-bit product register.
// The register is then arithmetic-shifted right by two.
// Sixteen iterations complete one multiply.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   data_operandA  multiplicand (two's complement), captured on a start edge
//   data_operandB  multiplier (two's complement), captured on a start edge
//   ctrl_MULT      start strobe; a start in any state (re)launches a multiply
//   data_result    low 32 bits of the signed product, held until the next completion
//   data_exception product does not fit in 32 signed bits
//   data_resultRDY one-cycle pulse when data_result/data_exception are updated
//   data_busy      high while iterating
//
// cla_full_adder (also in this file): a 32-bit two-level carry-lookahead adder.
//   a, b, cin  addends and carry-in
//   sum, cout  sum and carry-out

module cla_full_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] gen_s;
  logic [31:0] prop_s;
  logic [32:0] carry_s;
  logic [7:0]  grp_gen_s;
  logic [7:0]  grp_prop_s;
  logic [8:0]  grp_carry_s;

  // Group generate/propagate over 4-bit nibbles, lookahead across groups, then carries within each group
  always_comb begin
    gen_s          = a & b;
    prop_s         = a ^ b;
    grp_gen_s      = 8'd0;
    grp_prop_s     = 8'd0;
    grp_carry_s    = 9'd0;
    carry_s        = 33'd0;
    for (int k = 0; k < 8; k++) begin
      grp_gen_s[k]  = 1'b0;
      grp_prop_s[k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        grp_gen_s[k]  = gen_s[4*k+j] | (prop_s[4*k+j] & grp_gen_s[k]);
        grp_prop_s[k] = grp_prop_s[k] & prop_s[4*k+j];
      end
    end
    grp_carry_s[0] = cin;
    for (int k = 0; k < 8; k++) begin
      grp_carry_s[k+1] = grp_gen_s[k] | (grp_prop_s[k] & grp_carry_s[k]);
    end
    for (int k = 0; k < 8; k++) begin
      carry_s[4*k] = grp_carry_s[k];
      for (int j = 0; j < 3; j++) begin
        carry_s[4*k+j+1] = gen_s[4*k+j] | (prop_s[4*k+j] & carry_s[4*k+j]);
      end
    end
    carry_s[32] = grp_carry_s[8];
  end

  assign sum  = prop_s ^ carry_s[31:0];
  assign cout = carry_s[32];

endmodule

module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [33:0] m_r;
  logic [66:0] p_r;
  logic [4:0]  counter_r;

  logic [33:0] sel_s;
  logic        sub_s;
  logic [33:0] addend_s;
  logic [31:0] sum_lo_s;
  logic        carry_lo_s;
  logic [1:0]  sum_hi_s;
  logic [33:0] acc_s;
  logic [66:0] p_next_s;

  // The 64-bit product P[64:1] fits in 32 signed bits only if its upper half copies bit 31
  function automatic logic product_overflow(input logic [66:0] p);
    return (p[64:33] != {32{p[32]}});
  endfunction

  // Radix-4 Booth recoding of the low three product bits into a signed multiple of M
  always_comb begin
    sel_s = 34'd0;
    sub_s = 1'b0;
    case (p_r[2:0])
      3'b000, 3'b111: begin
        sel_s = 34'd0;
        sub_s = 1'b0;
      end
      3'b001, 3'b010: begin
        sel_s = m_r;
        sub_s = 1'b0;
      end
      3'b011: begin
        sel_s = {m_r[32:0], 1'b0};
        sub_s = 1'b0;
      end
      3'b100: begin
        sel_s = {m_r[32:0], 1'b0};
        sub_s = 1'b1;
      end
      3'b101, 3'b110: begin
        sel_s = m_r;
        sub_s = 1'b1;
      end
      default: begin
        sel_s = 34'd0;
        sub_s = 1'b0;
      end
    endcase
  end

  // Subtraction is done as add of the inverted multiple with carry-in set
  assign addend_s = sub_s ? ~sel_s : sel_s;

  cla_full_adder u_cla (
    .a    (p_r[64:33]),
    .b    (addend_s[31:0]),
    .cin  (sub_s),
    .sum  (sum_lo_s),
    .cout (carry_lo_s)
  );

  // The top two accumulator bits extend the 32-bit add using the adder's carry-out
  assign sum_hi_s = p_r[66:65] + addend_s[33:32] + {1'b0, carry_lo_s};
  assign acc_s    = {sum_hi_s, sum_lo_s};
  assign p_next_s = {{2{acc_s[33]}}, acc_s, p_r[32:2]};

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      m_r            <= 34'd0;
      p_r            <= 67'd0;
      counter_r      <= 5'd0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
    end else if (ctrl_MULT) begin
      // A start in any state (re)loads operands; an in-flight multiply is dropped silently
      m_r            <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
      p_r            <= {34'd0, data_operandB, 1'b0};
      counter_r      <= 5'd0;
      state_r        <= RUN;
      data_busy      <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          p_r       <= p_next_s;
          counter_r <= counter_r + 5'd1;
          if (counter_r == 5'd15) begin
            state_r        <= DONE;
            data_busy      <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= p_next_s[32:1];
            data_exception <= product_overflow(p_next_s);
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r        <= IDLE;
          data_resultRDY <= 1'b0;
        end
        IDLE: begin
          state_r        <= IDLE;
          data_resultRDY <= 1'b0;
          data_busy      <= 1'b0;
        end
        default: begin
          state_r        <= IDLE;
          data_resultRDY <= 1'b0;
          data_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed cases, abort/reset cases and random pairs.
// Expected values come from a 64-bit signed multiply.
module tb_booth_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] prev_res = 32'd0;
  logic        prev_exc = 1'b0;
  int          rdy_seen;

  always #5 clock = ~clock;

  booth_multiplier #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  // Reference: {exception, low 32 bits} of the full signed product
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] pv;
    logic        exc;
    p   = longint'($signed(a)) * longint'($signed(b));
    pv  = p;
    exc = (longint'($signed(pv[31:0])) != p);
    return {exc, pv[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check("busy_after_start", {31'd0, data_busy}, 32'd1);
    check("rdy_after_start", {31'd0, data_resultRDY}, 32'd0);
    check("result_hold_at_start", data_result, prev_res);
    check("exc_hold_at_start", {31'd0, data_exception}, {31'd0, prev_exc});
  endtask

  task automatic finish(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [32:0] exp;
    int          lat;
    int          busy_n;
    exp    = ref_mul(a, b);
    lat    = 0;
    busy_n = 1;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clock);
      #1;
      data_operandA = $urandom;
      data_operandB = $urandom;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
      if (data_busy) busy_n++;
      else check({tag, "_result_hold_run"}, data_result, prev_res);
    end
    check({tag, "_latency"}, lat, 32'd16);
    check({tag, "_busy_cycles"}, busy_n, 32'd16);
    check({tag, "_busy_at_rdy"}, {31'd0, data_busy}, 32'd0);
    check({tag, "_result"}, data_result, exp[31:0]);
    check({tag, "_exception"}, {31'd0, data_exception}, {31'd0, exp[32]});
    prev_res = exp[31:0];
    prev_exc = exp[32];
    @(posedge clock);
    #1;
    check({tag, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_result_held"}, data_result, prev_res);
  endtask

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
    start(a, b);
    finish(a, b, tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0001;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, data_busy}, 32'd0);
    reset = 1'b0;

    // Directed products, including the extreme operands
    do_mult(32'd3, 32'd5, "3x5");
    do_mult(32'hFFFF_FFF9, 32'd6, "m7x6");
    do_mult(32'd0, 32'hFFFF_FFFF, "0xm1");
    do_mult(32'h7FFF_FFFF, 32'd2, "maxx2");
    do_mult(32'h8000_0000, 32'd1, "minx1");
    do_mult(32'h8000_0000, 32'hFFFF_FFFF, "minxm1");
    do_mult(32'h8000_0000, 32'h8000_0000, "minxmin");
    do_mult(32'd0, 32'd0, "0x0");

    // Restart during RUN: only the second multiply may report
    start(32'd100, 32'd100);
    rdy_seen = 0;
    repeat (7) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    start(32'hFFFF_FFFD, 32'd4);
    finish(32'hFFFF_FFFD, 32'd4, "abort");
    check("abort_no_early_rdy", rdy_seen, 32'd0);

    // Reset in the middle of a multiply
    start(32'd9, 32'd9);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exception", {31'd0, data_exception}, 32'd0);
    check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midreset_busy", {31'd0, data_busy}, 32'd0);
    prev_res = 32'd0;
    prev_exc = 1'b0;
    @(negedge clock);
    reset    = 1'b0;
    rdy_seen = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    check("midreset_no_rdy", rdy_seen, 32'd0);
    do_mult(32'd9, 32'd9, "9x9");

    // Random signed pairs with a bias toward the extreme values
    for (int n = 0; n < 16; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = pick();
      rb = pick();
      do_mult(ra, rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Multicycle signed 32x32 multiplier using radix-4 modified Booth recoding.
- Sits downstream of the 32-bit CLA adder and is its primary consumer; every partial-product add/subtract goes through cla_full_adder instances.
- Feeds the processor's multdiv result path: low 32 bits of the product plus an overflow exception flag.
- Stall logic uses data_busy / data_resultRDY to hold the pipeline.

Parameters:
- WIDTH, 32, operand/result width; only 32 supported (iteration count fixed at WIDTH/2 = 16).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data_operandA  in  32  multiplicand, two's complement; sampled only on a start edge
- data_operandB  in  32  multiplier, two's complement; sampled only on a start edge
- ctrl_MULT  in  1  start strobe; sampled every edge
- data_result  out  32  low 32 bits of the signed product
- data_exception  out  1  product does not fit in 32 signed bits
- data_resultRDY  out  1  one-cycle pulse when the result is valid
- data_busy  out  1  high while iterating

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high.
- Reset:
  - state=IDLE, counter=0, product register cleared, multiplicand register cleared.
  - data_result=0, data_exception=0, data_resultRDY=0, data_busy=0.
  - Reset takes priority over ctrl_MULT on the same edge.
- States: IDLE, RUN, DONE.
- Start (any state, ctrl_MULT=1 at edge E0):
  - M <= A, sign-extended to 34 bits.
  - P (67 bits) <= {34'b0, B, 1'b0}; counter <= 0; state <= RUN; data_busy <= 1.
  - A start during RUN aborts the current multiply and restarts with the new operands; no RDY pulse is produced for the aborted one.
- RUN, each edge E1..E16:
  - Recode q = P[2:0]: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Upper 34 bits P[66:33] <= P[66:33] + sel, where subtract = add ~sel with carry-in 1.
  - The add uses cla_full_adder for bits [31:0]. Bits [33:32] come from sign extension plus that adder's carry.
  - P then arithmetic-shifts right by 2; counter++.
  - On edge E16 (counter reaches 15->16): state <= DONE, data_busy <= 0, data_resultRDY <= 1.
  - data_result <= final P[32:1]. data_exception <= 1 iff final P[64:33] is not all equal to P[32] (the 64-bit product P[64:1] does not sign-fit in 32 bits).
- Latency: start at E0 -> data_resultRDY high exactly during the cycle between E16 and E17 (16 cycles).
- DONE, next edge: state <= IDLE, data_resultRDY <= 0.
  - A ctrl_MULT on that edge restarts as above (RDY still drops).
- Hold: data_result and data_exception hold their values until the next completed multiply or reset. They do not change at a start or during RUN.
- Operand inputs may change freely after E0 without affecting the result.
- ctrl_MULT held high across multiple edges restarts on every edge; completion requires the strobe to be deasserted for 16 consecutive edges.
- Boundary cases, all required:
  - -2^31 * -2^31 = 2^62: result 0, exception 1.
  - Zero operands give result 0, exception 0.
  - The 2M/-2M terms of M = -2^31 must not overflow the 34-bit accumulator.

Test Plan:
- Reset, then ctrl_MULT with A=3, B=5 -> RDY pulses exactly 16 cycles after the start edge; result 0x0000000F, exception 0; busy high for 16 cycles; RDY width 1 cycle.
- A=-7 (0xFFFFFFF9), B=6 -> result 0xFFFFFFD6 (-42), exception 0; A=0, B=0xFFFFFFFF -> result 0, exception 0.
- A=0x7FFFFFFF, B=2 -> result 0xFFFFFFFE, exception 1; A=0x80000000, B=1 -> result 0x80000000, exception 0; A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
- Start A=100, B=100; at cycle 8 restart with A=-3, B=4 -> single RDY pulse 16 cycles after the second start, result 0xFFFFFFF4; no pulse for the first operation.
- Start A=9, B=9; assert reset at cycle 5 -> all outputs 0 on the next edge, no RDY pulse. A subsequent start with A=9, B=9 yields 0x00000051.
- Randomized signed pairs including ±2^31 and ±1, compared to a 64-bit reference model -> result and exception match on every case; operands changed after E0 do not affect the result.
